// File: rtl/inst_prefetch_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module : inst_prefetch_buffer_pkg
// Brief  : Shared widths, defaults and entry type for the prefetch buffer.
// Rev    : 1.0 - initial release
// ============================================================================
package inst_prefetch_buffer_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned INST_BYTES       = 4;
    localparam int unsigned DEFAULT_DEPTH    = 4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(INST_BYTES - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module : prefetch_fifo
// Brief  : Power-of-two FIFO of {pc, inst} entries with flush and occupancy.
// Rev    : 1.0 - initial release
// ============================================================================
module prefetch_fifo
    import inst_prefetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  fetch_entry_t             wdata_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fetch_entry_t             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int unsigned c_AW = $clog2(DEPTH);
    localparam int unsigned c_CW = c_AW + 1;

    fetch_entry_t      mem_q [DEPTH];
    logic [c_AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [c_CW-1:0]   count_q;
    logic              w_full, w_empty, w_push, w_pop;

    assign w_full  = (count_q == c_CW'(DEPTH));
    assign w_empty = (count_q == '0);
    // A pop frees the slot in the same edge, so push-on-full is legal alongside it.
    assign w_push  = push_i && !flush_i && (!w_full || pop_i);
    assign w_pop   = pop_i  && !flush_i && !w_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + c_AW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + c_AW'(1);
            count_q <= count_q + c_CW'(w_push) - c_CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Storage is not reset; the head reads as zero whenever nothing is queued.
    assign rdata_o = w_empty ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = w_empty;

endmodule
`default_nettype wire

// File: rtl/inst_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module : inst_prefetch_buffer
// Brief  : Credit-based instruction prefetcher with redirect flush and drop.
// Rev    : 1.0 - initial release
// ============================================================================
module inst_prefetch_buffer
    import inst_prefetch_buffer_pkg::*;
#(
    parameter int unsigned     DEPTH    = DEFAULT_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req_valid,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    input  logic [XLEN-1:0]  imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_inst,
    output logic [XLEN-1:0]  out_pc,
    input  logic             out_ready
);

    localparam int unsigned c_CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [c_CW-1:0] outstanding_q, outstanding_d;
    logic [c_CW-1:0] drop_cnt_q, drop_cnt_d;

    logic [c_CW-1:0] w_count;
    logic            w_fifo_empty;
    logic            w_credit, w_req_fire, w_rsp_fire, w_dropping;
    logic            w_push, w_pop;
    logic [XLEN-1:0] w_redirect_pc;
    fetch_entry_t    w_head, w_push_entry;

    // Every outstanding request owns a FIFO slot, so the FIFO cannot overflow.
    assign w_credit       = ({1'b0, w_count} + {1'b0, outstanding_q}) < (c_CW+1)'(DEPTH);
    assign imem_req_valid = reset && w_credit && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;

    assign w_req_fire    = imem_req_valid && imem_req_ready;
    assign w_rsp_fire    = imem_rsp_valid && (outstanding_q != '0);
    assign w_dropping    = (drop_cnt_q != '0);
    assign w_push        = w_rsp_fire && !w_dropping && !redirect_valid;
    assign w_pop         = out_valid && out_ready && !redirect_valid;
    assign w_redirect_pc = word_align(redirect_pc);

    assign w_push_entry.pc   = rsp_pc_q;
    assign w_push_entry.inst = imem_rsp_data;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + c_CW'(w_req_fire) - c_CW'(w_rsp_fire);

        if (redirect_valid) begin
            fetch_pc_d = w_redirect_pc;
            rsp_pc_d   = w_redirect_pc;
            // Everything still in flight now belongs to the abandoned path.
            drop_cnt_d = outstanding_q - c_CW'(w_rsp_fire);
        end else begin
            if (w_req_fire)               fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
            if (w_push)                   rsp_pc_d   = rsp_pc_q + XLEN'(INST_BYTES);
            if (w_rsp_fire && w_dropping) drop_cnt_d = drop_cnt_q - c_CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_push),
        .wdata_i (w_push_entry),
        .pop_i   (w_pop),
        .flush_i (redirect_valid),
        .rdata_o (w_head),
        .count_o (w_count),
        .empty_o (w_fifo_empty)
    );

    assign out_valid = !w_fifo_empty;
    assign out_inst  = w_head.inst;
    assign out_pc    = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_inst_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module : tb_inst_prefetch_buffer
// Brief  : Randomised bench with an in-order memory and an epoch-based model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_inst_prefetch_buffer;

    localparam int unsigned c_DEPTH = 4;
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;

    inst_prefetch_buffer #(
        .DEPTH    (c_DEPTH),
        .RESET_PC (c_RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int unsigned due;
    } mem_req_t;

    mem_req_t    mem_q[$];     // requests the memory has accepted, oldest first
    logic [31:0] exp_q[$];     // PCs decode should see, oldest first
    logic [31:0] m_fetch;
    int unsigned m_epoch;
    int unsigned cyc;
    int          n_checks;
    int          n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_out_inst"},  out_inst, 32'd0);
        check_eq({tag, "_out_pc"},    out_pc, 32'd0);
        check_eq({tag, "_req_addr"},  imem_req_addr, c_RESET_PC);
    endtask

    task automatic clear_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = 1'b0;
    endtask

    task automatic model_reset();
        mem_q.delete();
        exp_q.delete();
        m_fetch = c_RESET_PC;
        m_epoch++;
    endtask

    // One phase of random traffic; optional forced redirect on its first cycle
    // and optional asynchronous reset at cycle rst_at.
    task automatic run_phase(input int cycles, input int rdy_pct, input int ord_pct,
                             input int redir_pct, input int lat_max,
                             input bit first_redir, input logic [31:0] first_pc,
                             input int rst_at);
        logic exp_req;
        logic rsp_real;
        for (int n = 0; n < cycles; n++) begin
            if (n == rst_at) begin
                reset = 1'b0;
                clear_inputs();
                #1;
                check_reset_values("async_rst");
                model_reset();
                @(posedge clk); #1;
                @(posedge clk); #1;
                reset = 1'b1;
                cyc += 2;
            end
            imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
            out_ready      = ($urandom_range(0, 99) < ord_pct);
            redirect_valid = (first_redir && n == 0) || ($urandom_range(0, 99) < redir_pct);
            if (first_redir && n == 0)
                redirect_pc = first_pc;
            else if ($urandom_range(0, 3) == 0)
                redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else
                redirect_pc = $urandom;
            rsp_real = 1'b0;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_q[0].addr);
                rsp_real       = 1'b1;
            end else if (mem_q.size() == 0 && $urandom_range(0, 7) == 0) begin
                imem_rsp_valid = 1'b1;  // stray response with nothing outstanding
                imem_rsp_data  = $urandom;
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
            end

            @(negedge clk);
            exp_req = ((exp_q.size() + mem_q.size()) < c_DEPTH) && !redirect_valid;
            check_eq("req_valid", 32'(imem_req_valid), 32'(exp_req));
            check_eq("req_addr", imem_req_addr, m_fetch);
            check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check_eq("out_pc", out_pc, exp_q[0]);
                check_eq("out_inst", out_inst, mem_word(exp_q[0]));
            end

            if (!redirect_valid && out_ready && exp_q.size() != 0)
                void'(exp_q.pop_front());
            if (rsp_real) begin
                mem_req_t r;
                r = mem_q.pop_front();
                if (!redirect_valid && r.epoch == m_epoch)
                    exp_q.push_back(r.addr);
            end
            if (exp_req && imem_req_ready) begin
                mem_q.push_back('{addr: m_fetch, epoch: m_epoch,
                                  due: cyc + 32'($urandom_range(1, lat_max))});
                m_fetch = m_fetch + 32'd4;
            end
            if (redirect_valid) begin
                exp_q.delete();
                m_epoch++;
                m_fetch = redirect_pc & ~32'd3;
            end

            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        m_epoch  = 0;
        reset    = 1'b0;
        clear_inputs();
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_reset_values("por");
        reset = 1'b1;

        // streaming, single-cycle memory, decode always ready
        run_phase(24, 100, 100, 0, 1, 1'b0, 32'd0, -1);
        // decode stalled: credits must cap requests at DEPTH, head stays put
        run_phase(16, 100, 0, 0, 1, 1'b0, 32'd0, -1);
        run_phase(16, 100, 100, 0, 1, 1'b0, 32'd0, -1);
        // slow memory, forced redirect with unaligned target
        run_phase(40, 100, 100, 0, 3, 1'b1, 32'h0000_0203, -1);
        // redirect into the top of the address space to exercise wrap
        run_phase(30, 100, 100, 0, 2, 1'b1, 32'hFFFF_FFF5, -1);
        // heavy random traffic with frequent redirects and a mid-stream reset
        run_phase(600, 70, 60, 8, 3, 1'b0, 32'd0, 300);
        run_phase(600, 50, 40, 15, 4, 1'b1, 32'h0000_0100, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
